fetch_line_streamer: RTL and testbench

- Read-side initiator for the line-wide data cache/memory interface: issues line read addresses, waits for the memory's valid, captures the INW-bit line and streams it out one DATAW word per handshake.
- Sits between the memory wrapper and the instruction decode/consumer.
- Fetches the next sequential line automatically after the last word of the current line is consumed.
- Supports redirect (branch) with discard of any in-flight line.

---
 rtl/fetch_line_streamer.sv | 130 +++++++++++++
 tb/tb_fetch_line_streamer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_line_streamer.sv
// Line-wide read initiator: requests a memory line, captures it and streams it out
// one word per handshake, auto-fetching the next sequential line and honouring redirects.
module fetch_line_streamer #(
    parameter int DATAW    = 16,
    parameter int INW      = 512,
    parameter int ADDRW    = 32,
    parameter int NUMWORDS = INW / DATAW,
    parameter int OFFW     = $clog2(NUMWORDS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             redirect,
    input  logic [ADDRW-1:0] start_addr,
    output logic             mem_write,
    output logic [ADDRW-1:0] mem_addr,
    output logic             mem_req,
    input  logic             mem_valid,
    input  logic [INW-1:0]   mem_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DATAW-1:0] out_word,
    output logic [ADDRW-1:0] out_addr,
    output logic             busy
);

    localparam logic [ADDRW-1:0] OFF_MASK = ADDRW'(NUMWORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_STREAM,
        S_DRAIN
    } state_t;

    state_t           state_q, state_d;
    logic [ADDRW-1:0] pc_q, pc_d;
    logic [ADDRW-1:0] line_q, line_d;
    logic [INW-1:0]   buf_q, buf_d;
    logic [ADDRW-1:0] pc_inc;
    logic             last_word;

    logic [DATAW-1:0] words [NUMWORDS];

    generate
        for (genvar gi = 0; gi < NUMWORDS; gi++) begin : g_words
            assign words[gi] = buf_q[gi*DATAW +: DATAW];
        end
    endgenerate

    assign pc_inc    = pc_q + ADDRW'(1);
    assign last_word = &pc_q[OFFW-1:0];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        line_d  = line_q;
        buf_d   = buf_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    pc_d    = start_addr;
                    line_d  = start_addr & ~OFF_MASK;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (redirect) begin
                    pc_d = start_addr;
                    if (mem_valid) begin
                        line_d  = start_addr & ~OFF_MASK;
                        state_d = S_REQ;
                    end else begin
                        // Old request must still complete; line_q keeps its address until then.
                        state_d = S_DRAIN;
                    end
                end else if (mem_valid) begin
                    buf_d   = mem_data;
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (redirect) begin
                    pc_d    = start_addr;
                    line_d  = start_addr & ~OFF_MASK;
                    state_d = S_REQ;
                end else if (out_ready) begin
                    pc_d = pc_inc;
                    if (last_word) begin
                        line_d  = pc_inc & ~OFF_MASK;
                        state_d = S_REQ;
                    end
                end
            end
            S_DRAIN: begin
                if (redirect) begin
                    pc_d = start_addr;
                end
                if (mem_valid) begin
                    line_d  = pc_d & ~OFF_MASK;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            line_q  <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            line_q  <= line_d;
            buf_q   <= buf_d;
        end
    end

    assign mem_write = 1'b0;
    assign mem_addr  = line_q;
    assign mem_req   = (state_q == S_REQ) || (state_q == S_DRAIN);
    assign out_valid = (state_q == S_STREAM);
    assign out_word  = words[pc_q[OFFW-1:0]];
    assign out_addr  = pc_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_fetch_line_streamer.sv
// Scoreboard bench for fetch_line_streamer: directed line fetches, backpressure,
// redirects in every state, address wrap and asynchronous reset.
module tb_fetch_line_streamer;

    localparam int DATAW = 16;
    localparam int INW   = 512;
    localparam int ADDRW = 32;
    localparam int NW    = INW / DATAW;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             redirect = 1'b0;
    logic [ADDRW-1:0] start_addr = '0;
    logic             mem_write;
    logic [ADDRW-1:0] mem_addr;
    logic             mem_req;
    logic             mem_valid = 1'b0;
    logic [INW-1:0]   mem_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [DATAW-1:0] out_word;
    logic [ADDRW-1:0] out_addr;
    logic             busy;

    int assertions = 0;
    int failures   = 0;
    logic [ADDRW+DATAW-1:0] exp_q[$];

    fetch_line_streamer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .redirect(redirect),
        .start_addr(start_addr), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_req(mem_req), .mem_valid(mem_valid), .mem_data(mem_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
        .out_addr(out_addr), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        assertions++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_words(input logic [ADDRW-1:0] line, input int first, input int last,
                              input logic [DATAW-1:0] base);
        for (int k = first; k <= last; k++) begin
            exp_q.push_back({line + ADDRW'(k), base + DATAW'(k)});
        end
    endtask

    task automatic do_start(input logic [ADDRW-1:0] a);
        start_addr = a;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic mem_respond(input string name, input logic [ADDRW-1:0] exp_addr,
                               input logic [DATAW-1:0] base);
        int n;
        n = 0;
        while (!mem_req && n < 20) begin
            tick();
            n++;
        end
        check({name, "_req"}, 64'(mem_req), 64'd1);
        check({name, "_addr"}, 64'(mem_addr), 64'(exp_addr));
        for (int k = 0; k < NW; k++) mem_data[k*DATAW +: DATAW] = base + DATAW'(k);
        mem_valid = 1'b1;
        tick();
        mem_valid = 1'b0;
    endtask

    task automatic drain(input string name, input int exp_cycles);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        check({name, "_cycles"}, 64'(n), 64'(exp_cycles));
        if (exp_q.size() != 0) begin
            check({name, "_timeout_left"}, 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_write", 64'(mem_write), 64'd0);
        rst_n = 1'b1;
    endtask

    // Pops and compares on every accepted word; also checks hold under backpressure.
    task automatic monitor_loop();
        logic                   stalled;
        logic [ADDRW+DATAW-1:0] held;
        logic [ADDRW+DATAW-1:0] exp;
        stalled = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (out_valid && stalled) check("hold", 64'({out_addr, out_word}), 64'(held));
            if (out_valid && out_ready && !redirect && rst_n) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word_addr", 64'(out_addr), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    exp = exp_q.pop_front();
                    check("word", 64'({out_addr, out_word}), 64'(exp));
                end
            end
            stalled = out_valid && !out_ready && !redirect;
            held = {out_addr, out_word};
        end
    endtask

    initial begin
        logic [3:0] pat;
        pat = 4'b1001;
        fork
            monitor_loop();
        join_none

        // Full line from 0x40, then sequential request for 0x60.
        do_reset();
        do_start(32'h40);
        check("t1_req", 64'(mem_req), 64'd1);
        check("t1_addr", 64'(mem_addr), 64'h40);
        check("t1_busy", 64'(busy), 64'd1);
        push_words(32'h40, 0, 31, 16'h1000);
        out_ready = 1'b1;
        mem_respond("t1_resp", 32'h40, 16'h1000);
        drain("t1", 32);
        check("t1_next_req", 64'(mem_req), 64'd1);
        check("t1_next_addr", 64'(mem_addr), 64'h60);

        // Mid-line start: only offsets 29..31.
        do_reset();
        do_start(32'h3D);
        check("t2_addr", 64'(mem_addr), 64'h20);
        push_words(32'h20, 29, 31, 16'h2000);
        mem_respond("t2_resp", 32'h20, 16'h2000);
        drain("t2", 3);
        check("t2_next_addr", 64'(mem_addr), 64'h40);
        do_start(32'h500);
        check("t2_start_ignored", 64'(mem_addr), 64'h40);

        // Backpressure pattern 1,0,0,1 over a full line.
        push_words(32'h40, 0, 31, 16'h3000);
        mem_respond("t3_resp", 32'h40, 16'h3000);
        begin
            int n;
            n = 0;
            while (exp_q.size() != 0 && n < 200) begin
                out_ready = pat[3 - (n % 4)];
                tick();
                n++;
            end
            check("t3_left", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
        out_ready = 1'b1;
        check("t3_next_addr", 64'(mem_addr), 64'h60);

        // Redirect while a request is outstanding, then again while draining.
        do_reset();
        do_start(32'h80);
        start_addr = 32'h300;
        redirect = 1'b1;
        tick();
        redirect = 1'b0;
        check("t4_drain_req", 64'(mem_req), 64'd1);
        check("t4_drain_addr", 64'(mem_addr), 64'h80);
        check("t4_drain_ov", 64'(out_valid), 64'd0);
        tick();
        start_addr = 32'h205;
        redirect = 1'b1;
        tick();
        redirect = 1'b0;
        check("t4_drain_addr2", 64'(mem_addr), 64'h80);
        mem_respond("t4_discard", 32'h80, 16'hDEAD);
        check("t4_new_req", 64'(mem_req), 64'd1);
        check("t4_new_addr", 64'(mem_addr), 64'h200);
        check("t4_new_ov", 64'(out_valid), 64'd0);
        push_words(32'h200, 5, 31, 16'h4000);
        mem_respond("t4_resp", 32'h200, 16'h4000);
        drain("t4", 27);
        check("t4_next_addr", 64'(mem_addr), 64'h220);

        // Redirect in STREAM coincident with out_ready; the presented word is dropped.
        push_words(32'h220, 0, 2, 16'h5000);
        mem_respond("t5_resp", 32'h220, 16'h5000);
        tick();
        tick();
        tick();
        check("t5_ov_before", 64'(out_valid), 64'd1);
        start_addr = 32'h1F0;
        redirect = 1'b1;
        tick();
        redirect = 1'b0;
        check("t5_ov_after", 64'(out_valid), 64'd0);
        check("t5_req", 64'(mem_req), 64'd1);
        check("t5_addr", 64'(mem_addr), 64'h1E0);
        check("t5_sb_empty", 64'(exp_q.size()), 64'd0);

        // Redirect with mem_valid in REQ: discard without DRAIN, then wrap to line 0.
        for (int k = 0; k < NW; k++) mem_data[k*DATAW +: DATAW] = 16'hBAD0;
        mem_valid = 1'b1;
        start_addr = 32'hFFFF_FFFE;
        redirect = 1'b1;
        tick();
        mem_valid = 1'b0;
        redirect = 1'b0;
        check("t5b_addr", 64'(mem_addr), 64'hFFFF_FFE0);
        check("t5b_ov", 64'(out_valid), 64'd0);
        push_words(32'hFFFF_FFE0, 30, 31, 16'h6000);
        mem_respond("t5b_resp", 32'hFFFF_FFE0, 16'h6000);
        drain("t5b", 2);
        check("t5b_wrap_req", 64'(mem_req), 64'd1);
        check("t5b_wrap_addr", 64'(mem_addr), 64'h0);

        // Asynchronous reset mid-STREAM; a late mem_valid must produce nothing.
        out_ready = 1'b0;
        mem_respond("t6_resp", 32'h0, 16'h7000);
        check("t6_ov", 64'(out_valid), 64'd1);
        check("t6_word", 64'(out_word), 64'h7000);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_ov", 64'(out_valid), 64'd0);
        check("t6_async_req", 64'(mem_req), 64'd0);
        check("t6_async_busy", 64'(busy), 64'd0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        mem_valid = 1'b1;
        tick();
        mem_valid = 1'b0;
        tick();
        tick();
        check("t6_post_ov", 64'(out_valid), 64'd0);
        check("t6_post_busy", 64'(busy), 64'd0);
        check("t6_post_req", 64'(mem_req), 64'd0);
        check("final_sb_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
